// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM layer sequencer and its datapaths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lstm_pkg;

  localparam int INPUT_SZ        = 2;
  localparam int HIDDEN_SZ       = 8;
  localparam int OUTPUT_SZ       = 1;
  localparam int DSP48_PER_ROW_G = 2;
  localparam int DSP48_PER_ROW_M = 2;
  localparam int MAC_LAT         = 3;
  localparam int ELEM_LAT        = 4;

  // Fixed-point format used by the MAC and elementwise datapaths.
  localparam int QN       = 8;
  localparam int QM       = 8;
  localparam int BITWIDTH = QN + QM;

  // Ceiling log2, floored at 1 so that single-entry ranges still get a 1-bit index.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Chunks per gate row and per output row.
  localparam int CG = (INPUT_SZ + HIDDEN_SZ) / DSP48_PER_ROW_G;
  localparam int CM = HIDDEN_SZ / DSP48_PER_ROW_M;

  localparam int RW = clog2(HIDDEN_SZ);
  localparam int CW = clog2(INPUT_SZ + HIDDEN_SZ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE,
    S_G_DRAIN,
    S_ELEM,
    S_E_DRAIN,
    S_OUT,
    S_O_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/lstm_chunk_counter.sv
// Nested row/chunk counter: chunk runs 0..CHUNKS-1 inside each row, rows 0..ROWS-1.
// Latency: flags are combinational from the current count; count advances on step.
// Backpressure: none; holds its position while step is low, wraps to 0 after the final chunk.
module lstm_chunk_counter #(
  parameter int ROWS   = 8,
  parameter int CHUNKS = 5,
  parameter int RW     = 3,
  parameter int KW     = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          step,
  output logic [RW-1:0] row,
  output logic [KW-1:0] chunk,
  output logic          first,
  output logic          last,
  output logic          done
);

  assign first = (chunk == '0);
  assign last  = (chunk == KW'(CHUNKS - 1));
  assign done  = last && (row == RW'(ROWS - 1));

  // Advance chunk within a row, then the row; the final chunk returns both to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      row   <= '0;
      chunk <= '0;
    end else if (step) begin
      if (last) begin
        chunk <= '0;
        row   <= done ? '0 : row + 1'b1;
      end else begin
        chunk <= chunk + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lstm_sequencer.sv
// Steps one LSTM layer through gate MACs, elementwise update and dense output per sample.
// Latency: dataReady 63 cycles after the edge that samples newSample; all outputs are registered.
// Backpressure: none; newSample is only honoured in IDLE and is otherwise dropped.
module lstm_sequencer
  import lstm_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          newSample,
  output logic          busy,
  output logic          dataReady,
  output logic [RW-1:0] rowAddr,
  output logic [CW-1:0] colAddr,
  output logic          macEn,
  output logic          macClr,
  output logic          gateWr,
  output logic [RW-1:0] gateWrAddr,
  output logic          elemEn,
  output logic [RW-1:0] elemAddr,
  output logic          outStage,
  output logic          outWr,
  output logic          hSel
);

  localparam int GKW = clog2(CG);
  localparam int MKW = clog2(CM);
  localparam int ORW = clog2(OUTPUT_SZ);
  localparam int TW  = clog2(HIDDEN_SZ + MAC_LAT + ELEM_LAT);

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic           g_step, g_first, g_last, g_done;
  logic [RW-1:0]  g_row;
  logic [GKW-1:0] g_chunk;
  logic           m_step, m_first, m_last, m_done;
  logic [ORW-1:0] m_row;
  logic [MKW-1:0] m_chunk;

  logic          busy_c, mac_en_c, mac_clr_c, elem_en_c, out_stage_c, done_c;
  logic          g_last_c, m_last_c;
  logic [RW-1:0] row_c, elem_addr_c;
  logic [CW-1:0] col_c;

  logic                gate_last_q, out_last_q;
  logic [MAC_LAT-1:0]  gwr_dly, owr_dly;
  logic [RW-1:0]       gaddr_dly [MAC_LAT];

  lstm_chunk_counter #(.ROWS(HIDDEN_SZ), .CHUNKS(CG), .RW(RW), .KW(GKW)) u_gate_cnt (
    .clock(clock), .reset(reset), .step(g_step),
    .row(g_row), .chunk(g_chunk), .first(g_first), .last(g_last), .done(g_done)
  );

  lstm_chunk_counter #(.ROWS(OUTPUT_SZ), .CHUNKS(CM), .RW(ORW), .KW(MKW)) u_out_cnt (
    .clock(clock), .reset(reset), .step(m_step),
    .row(m_row), .chunk(m_chunk), .first(m_first), .last(m_last), .done(m_done)
  );

  // State and stage timer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state and per-cycle control decode; timer-driven stages exit with the timer back at 0.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    g_step      = 1'b0;
    m_step      = 1'b0;
    busy_c      = (state_q != S_IDLE);
    mac_en_c    = 1'b0;
    mac_clr_c   = 1'b0;
    row_c       = '0;
    col_c       = '0;
    elem_en_c   = 1'b0;
    elem_addr_c = '0;
    out_stage_c = 1'b0;
    g_last_c    = 1'b0;
    m_last_c    = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (newSample) state_d = S_GATE;
      end
      S_GATE: begin
        g_step    = 1'b1;
        mac_en_c  = 1'b1;
        mac_clr_c = g_first;
        row_c     = g_row;
        col_c     = CW'(int'(g_chunk) * DSP48_PER_ROW_G);
        g_last_c  = g_last;
        if (g_done) state_d = S_G_DRAIN;
      end
      S_G_DRAIN: begin
        if (tmr_q == TW'(MAC_LAT - 1)) begin
          tmr_d   = '0;
          state_d = S_ELEM;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_ELEM: begin
        elem_en_c   = 1'b1;
        elem_addr_c = RW'(tmr_q);
        if (tmr_q == TW'(HIDDEN_SZ - 1)) begin
          tmr_d   = '0;
          state_d = S_E_DRAIN;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_E_DRAIN: begin
        if (tmr_q == TW'(ELEM_LAT - 1)) begin
          tmr_d   = '0;
          state_d = S_OUT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_OUT: begin
        m_step      = 1'b1;
        mac_en_c    = 1'b1;
        mac_clr_c   = m_first;
        out_stage_c = 1'b1;
        row_c       = RW'(m_row);
        col_c       = CW'(int'(m_chunk) * DSP48_PER_ROW_M);
        m_last_c    = m_last;
        if (m_done) state_d = S_O_DRAIN;
      end
      S_O_DRAIN: begin
        if (tmr_q == TW'(MAC_LAT - 1)) begin
          tmr_d   = '0;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers plus the MAC_LAT-deep row-result strobe delay lines (MAC_LAT >= 2).
  always_ff @(posedge clock) begin
    if (reset) begin
      busy        <= 1'b0;
      dataReady   <= 1'b0;
      rowAddr     <= '0;
      colAddr     <= '0;
      macEn       <= 1'b0;
      macClr      <= 1'b0;
      elemEn      <= 1'b0;
      elemAddr    <= '0;
      outStage    <= 1'b0;
      hSel        <= 1'b0;
      gate_last_q <= 1'b0;
      out_last_q  <= 1'b0;
      gwr_dly     <= '0;
      owr_dly     <= '0;
      for (int i = 0; i < MAC_LAT; i++) gaddr_dly[i] <= '0;
    end else begin
      busy        <= busy_c;
      dataReady   <= done_c;
      rowAddr     <= row_c;
      colAddr     <= col_c;
      macEn       <= mac_en_c;
      macClr      <= mac_clr_c;
      elemEn      <= elem_en_c;
      elemAddr    <= elem_addr_c;
      outStage    <= out_stage_c;
      if (done_c) hSel <= ~hSel;
      gate_last_q <= g_last_c;
      out_last_q  <= m_last_c;
      gwr_dly     <= {gwr_dly[MAC_LAT-2:0], gate_last_q};
      owr_dly     <= {owr_dly[MAC_LAT-2:0], out_last_q};
      gaddr_dly[0] <= rowAddr;
      for (int i = 1; i < MAC_LAT; i++) gaddr_dly[i] <= gaddr_dly[i-1];
    end
  end

  assign gateWr     = gwr_dly[MAC_LAT-1];
  assign gateWrAddr = gaddr_dly[MAC_LAT-1];
  assign outWr      = owr_dly[MAC_LAT-1];

endmodule

// File: tb/tb_lstm_sequencer.sv
// Scoreboard bench for lstm_sequencer: stimulus pushes the expected trace, a monitor pops and compares.
// Latency: n/a.
// Backpressure: n/a.
module tb_lstm_sequencer;

  localparam int H   = 8;
  localparam int O   = 1;
  localparam int CG  = 5;   // (2+8)/2
  localparam int CM  = 4;   // 8/2
  localparam int DG  = 2;
  localparam int DM  = 2;
  localparam int ML  = 3;
  localparam int EL  = 4;
  localparam int T_GATE = 1;
  localparam int T_ELEM = T_GATE + H*CG + ML;
  localparam int T_OUT  = T_ELEM + H + EL;
  localparam int LAT    = T_OUT + O*CM + ML;   // 63

  logic       clock, reset, newSample;
  logic       busy, dataReady, macEn, macClr, gateWr, elemEn, outStage, outWr, hSel;
  logic [2:0] rowAddr, gateWrAddr, elemAddr;
  logic [3:0] colAddr;

  lstm_sequencer dut (
    .clock(clock), .reset(reset), .newSample(newSample),
    .busy(busy), .dataReady(dataReady), .rowAddr(rowAddr), .colAddr(colAddr),
    .macEn(macEn), .macClr(macClr), .gateWr(gateWr), .gateWrAddr(gateWrAddr),
    .elemEn(elemEn), .elemAddr(elemAddr), .outStage(outStage), .outWr(outWr), .hSel(hSel)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; int row; int col; int clr; int outs; } mac_t;
  typedef struct { int cyc; int val; } ev_t;

  // Expected trace: evq[0]=gateWr addr, [1]=elemEn addr, [2]=outWr (outStage value), [3]=dataReady (hSel value)
  mac_t mac_q[$];
  ev_t  evq[4][$];
  bit   exp_busy[int];
  int   next_free = 0;
  bit   hsel_m = 1'b0;
  int   idle_chk_cyc = -1;
  bit   finish_req = 1'b0;

  int ntest = 0;
  int nfail = 0;

  // ---------------- reference model ----------------
  task automatic push_run(input int e);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < CG; c++) mac_q.push_back('{e + T_GATE + r*CG + c, r, c*DG, (c == 0), 0});
    end
    for (int r = 0; r < H; r++) evq[0].push_back('{e + T_GATE + r*CG + CG - 1 + ML, r});
    for (int u = 0; u < H; u++) evq[1].push_back('{e + T_ELEM + u, u});
    for (int o = 0; o < O; o++) begin
      for (int c = 0; c < CM; c++) mac_q.push_back('{e + T_OUT + o*CM + c, o, c*DM, (c == 0), 1});
    end
    for (int o = 0; o < O; o++) evq[2].push_back('{e + T_OUT + o*CM + CM - 1 + ML, 0});
    hsel_m = ~hsel_m;
    evq[3].push_back('{e + LAT, int'(hsel_m)});
    for (int p = e + 1; p <= e + LAT; p++) exp_busy[p] = 1'b1;
    next_free = e + LAT + 1;
  endtask

  task automatic flush(input int s);
    while (mac_q.size() > 0 && mac_q[$].cyc >= s) void'(mac_q.pop_back());
    for (int k = 0; k < 4; k++) begin
      while (evq[k].size() > 0 && evq[k][$].cyc >= s) void'(evq[k].pop_back());
    end
    for (int p = s; p <= s + LAT; p++) if (exp_busy.exists(p)) exp_busy.delete(p);
    hsel_m = 1'b0;
    next_free = s + 1;
  endtask

  // Drive inputs for the next edge and record what that edge should cause.
  task automatic step(input bit ns, input bit rst);
    int s;
    @(negedge clock);
    s = cyc + 1;
    newSample = ns;
    reset = rst;
    if (rst) flush(s);
    else if (ns && s >= next_free) push_run(s);
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input int act, input int exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic check_ev(input int k, input bit strobe, input int val, input string nm);
    while (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
      ntest++; nfail++;
      $display("FAIL %s missing at cycle %0d: got no strobe, required value %0d", nm, evq[k][0].cyc, evq[k][0].val);
      void'(evq[k].pop_front());
    end
    if (strobe) begin
      if (evq[k].size() == 0 || evq[k][0].cyc != cyc) begin
        ntest++; nfail++;
        $display("FAIL %s unexpected at cycle %0d: got strobe with value %0d, required none", nm, cyc, val);
      end else begin
        cmp(nm, val, evq[k][0].val);
        void'(evq[k].pop_front());
      end
    end
  endtask

  task automatic check_mac();
    while (mac_q.size() > 0 && mac_q[0].cyc < cyc) begin
      ntest++; nfail++;
      $display("FAIL macEn missing at cycle %0d: got 0, required 1 (row %0d col %0d)", mac_q[0].cyc, mac_q[0].row, mac_q[0].col);
      void'(mac_q.pop_front());
    end
    if (macEn) begin
      if (mac_q.size() == 0 || mac_q[0].cyc != cyc) begin
        ntest++; nfail++;
        $display("FAIL macEn unexpected at cycle %0d: got 1, required 0", cyc);
      end else begin
        cmp("rowAddr", int'(rowAddr), mac_q[0].row);
        cmp("colAddr", int'(colAddr), mac_q[0].col);
        cmp("macClr", int'(macClr), mac_q[0].clr);
        cmp("outStage", int'(outStage), mac_q[0].outs);
        void'(mac_q.pop_front());
      end
    end
  endtask

  always @(negedge clock) begin
    if (cyc >= 1) begin
      cmp("busy", int'(busy), exp_busy.exists(cyc) ? 1 : 0);
      check_mac();
      check_ev(0, gateWr, int'(gateWrAddr), "gateWr");
      check_ev(1, elemEn, int'(elemAddr), "elemEn");
      check_ev(2, outWr, int'(outStage), "outWr");
      check_ev(3, dataReady, int'(hSel), "dataReady");
      if (cyc == idle_chk_cyc) begin
        cmp("idle_busy", int'(busy), 0);
        cmp("idle_dataReady", int'(dataReady), 0);
        cmp("idle_rowAddr", int'(rowAddr), 0);
        cmp("idle_colAddr", int'(colAddr), 0);
        cmp("idle_macEn", int'(macEn), 0);
        cmp("idle_macClr", int'(macClr), 0);
        cmp("idle_gateWr", int'(gateWr), 0);
        cmp("idle_gateWrAddr", int'(gateWrAddr), 0);
        cmp("idle_elemEn", int'(elemEn), 0);
        cmp("idle_elemAddr", int'(elemAddr), 0);
        cmp("idle_outStage", int'(outStage), 0);
        cmp("idle_outWr", int'(outWr), 0);
        cmp("idle_hSel", int'(hSel), 0);
      end
      if (finish_req) begin
        while (mac_q.size() > 0) begin
          ntest++; nfail++;
          $display("FAIL macEn never seen for cycle %0d: got 0, required 1", mac_q[0].cyc);
          void'(mac_q.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
          while (evq[k].size() > 0) begin
            ntest++; nfail++;
            $display("FAIL strobe %0d never seen for cycle %0d: got 0, required 1", k, evq[k][0].cyc);
            void'(evq[k].pop_front());
          end
        end
        cmp("hSel_final", int'(hSel), int'(hsel_m));
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    reset = 1'b1;
    newSample = 1'b0;
    repeat (3) step(0, 1);
    repeat (10) step(0, 0);
    idle_chk_cyc = cyc + 1;

    // single sample
    step(1, 0);
    repeat (70) step(0, 0);

    // newSample held high: back-to-back steps
    repeat (140) step(1, 0);
    repeat (70) step(0, 0);

    // reset at cycle 20 of the gate stage, then a clean run
    step(1, 0);
    repeat (19) step(0, 0);
    step(0, 1);
    repeat (70) step(0, 0);
    step(1, 0);
    repeat (70) step(0, 0);

    // stray requests while busy, including the DONE cycle
    step(1, 0);
    e = cyc;
    repeat (4) step(0, 0);
    step(1, 0);
    repeat (24) step(0, 0);
    step(1, 0);
    repeat (32) step(0, 0);
    if (cyc + 1 != e + LAT + 1) $display("note: stray pulse schedule drifted");
    step(1, 0);
    repeat (70) step(0, 0);

    // randomized requests with occasional reset
    repeat (600) step($urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0);
    repeat (70) step(0, 0);

    @(negedge clock);
    finish_req = 1'b1;
    repeat (5) @(negedge clock);
    $display("FAIL watchdog: monitor did not finish, got running, required stopped");
    $fatal(1);
  end

endmodule
